// File: rtl/param_ram_fifo.sv
// param_ram_fifo: RAM-backed synchronous FIFO with optional
// first-word-fall-through output and a side-band debug read port.
module param_ram_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 256,
  parameter int FWFT  = 1,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clockCore,
  input  logic             resetCore,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             pop,
  output logic [WIDTH-1:0] dataOut,
  input  logic [AW:0]      almostFullThreshold,
  input  logic [AW:0]      almostEmptyThreshold,
  output logic             full,
  output logic             empty,
  output logic             almostFullFlag,
  output logic             almostEmptyFlag,
  output logic [AW:0]      fifoDepth,
  output logic             overrun,
  output logic             underrun,
  input  logic             cpuReadValid,
  input  logic [AW-1:0]    cpuReadAddress,
  output logic             cpuReadAck,
  output logic [WIDTH-1:0] cpuReadData
);

  localparam bit         PF  = (FWFT != 0);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    cpu_addr;
  logic [AW-1:0]    cpu_sel;
  logic [AW-1:0]    rd_addr;
  logic [AW:0]      count;
  logic [AW:0]      ram_words;
  logic [AW:0]      inc;
  logic [AW:0]      dec;
  logic             out_valid;
  logic             cpu_pend;
  logic             push_ok;
  logic             pop_ok;
  logic             fifo_rd;
  logic             cpu_req;
  logic             cpu_take;
  logic             cpu_go;
  logic [WIDTH-1:0] rd_word;

  assign fifoDepth       = count;
  assign full            = (count == CAP);
  assign almostFullFlag  = (count >= almostFullThreshold);
  assign almostEmptyFlag = (count <= almostEmptyThreshold);
  assign empty           = PF ? !out_valid : (count == '0);

  // Accept/reject decisions and read-port arbitration (FIFO first).
  always_comb begin
    ram_words = count - {{AW{1'b0}}, (PF & out_valid)};
    pop_ok    = pop && !flush && !empty;
    push_ok   = push && !flush && (!full || pop_ok);
    if (PF) begin
      fifo_rd = !flush && (ram_words != '0) &&
                (!out_valid || pop_ok);
    end else begin
      fifo_rd = pop_ok;
    end
    inc      = {{AW{1'b0}}, push_ok};
    dec      = {{AW{1'b0}}, pop_ok};
    cpu_take = cpuReadValid && !cpu_pend && !flush;
    cpu_req  = (cpu_pend || cpuReadValid) && !flush;
    cpu_sel  = cpu_pend ? cpu_addr : cpuReadAddress;
    cpu_go   = cpu_req && !fifo_rd;
    rd_addr  = fifo_rd ? rd_ptr : cpu_sel;
    rd_word  = mem[rd_addr];
  end

  // RAM write port; contents survive reset and flush.
  always_ff @(posedge clockCore) begin
    if (push_ok) begin
      mem[wr_ptr] <= dataIn;
    end
  end

  // Pointers, occupancy and prefetch-valid bookkeeping.
  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + inc - dec;
      if (!PF) begin
        out_valid <= 1'b0;
      end else if (fifo_rd) begin
        out_valid <= 1'b1;
      end else if (pop_ok) begin
        out_valid <= 1'b0;
      end
    end
  end

  // FIFO read data register; holds between reads.
  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      dataOut <= '0;
    end else if (fifo_rd) begin
      dataOut <= rd_word;
    end
  end

  // One-cycle error pulses for dropped pushes and empty pops.
  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overrun  <= push && !flush && full && !pop_ok;
      underrun <= pop && !flush && empty;
    end
  end

  // Single-slot debug read: waits for a free read-port cycle.
  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      cpu_pend    <= 1'b0;
      cpu_addr    <= '0;
      cpuReadAck  <= 1'b0;
      cpuReadData <= '0;
    end else begin
      cpu_pend   <= cpu_req && !cpu_go;
      cpuReadAck <= cpu_go;
      if (cpu_take) begin
        cpu_addr <= cpuReadAddress;
      end
      if (cpu_go) begin
        cpuReadData <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_param_ram_fifo.sv
// tb_param_ram_fifo: randomized and directed checks of param_ram_fifo
// against a queue-based reference model.
module tb_param_ram_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             a_flush, a_push, a_pop;
  logic [WIDTH-1:0] a_din, a_dout;
  logic [4:0]       af_thr, ae_thr;
  logic             a_full, a_empty, a_af, a_ae;
  logic [4:0]       a_depth;
  logic             a_ovr, a_udr;
  logic             cpu_v;
  logic [3:0]       cpu_a;
  logic             cpu_ack;
  logic [WIDTH-1:0] cpu_d;

  logic             b_flush, b_push, b_pop;
  logic [WIDTH-1:0] b_din, b_dout;
  logic             b_full, b_empty, b_af, b_ae;
  logic [4:0]       b_depth;
  logic             b_ovr, b_udr;
  logic             b_cpu_v;
  logic [3:0]       b_cpu_a;
  logic             b_cpu_ack;
  logic [WIDTH-1:0] b_cpu_d;

  param_ram_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1)) dut_a (
    .clockCore(clk), .resetCore(rst_n), .flush(a_flush),
    .push(a_push), .dataIn(a_din), .pop(a_pop), .dataOut(a_dout),
    .almostFullThreshold(af_thr), .almostEmptyThreshold(ae_thr),
    .full(a_full), .empty(a_empty),
    .almostFullFlag(a_af), .almostEmptyFlag(a_ae),
    .fifoDepth(a_depth), .overrun(a_ovr), .underrun(a_udr),
    .cpuReadValid(cpu_v), .cpuReadAddress(cpu_a),
    .cpuReadAck(cpu_ack), .cpuReadData(cpu_d)
  );

  param_ram_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0)) dut_b (
    .clockCore(clk), .resetCore(rst_n), .flush(b_flush),
    .push(b_push), .dataIn(b_din), .pop(b_pop), .dataOut(b_dout),
    .almostFullThreshold(5'd12), .almostEmptyThreshold(5'd3),
    .full(b_full), .empty(b_empty),
    .almostFullFlag(b_af), .almostEmptyFlag(b_ae),
    .fifoDepth(b_depth), .overrun(b_ovr), .underrun(b_udr),
    .cpuReadValid(b_cpu_v), .cpuReadAddress(b_cpu_a),
    .cpuReadAck(b_cpu_ack), .cpuReadData(b_cpu_d)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    int               pe;
  } ent_t;

  ent_t             q[$];
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] shadow [DEPTH];
  logic [WIDTH-1:0] exp_dout0;
  int               ecnt = 0;
  int               wr_idx = 0;
  bit               exp_ovr, exp_udr;
  int               vectors = 0;
  int               miscompares = 0;

  function automatic logic [WIDTH-1:0] rnd();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // A word is on dataOut from one edge after its write,
  // once every older word has been consumed.
  function automatic bit model_empty();
    if (q.size() == 0) return 1'b1;
    return ecnt < q[0].pe + 1;
  endfunction

  task automatic model_reset();
    q.delete();
    q0.delete();
    wr_idx    = 0;
    exp_ovr   = 1'b0;
    exp_udr   = 1'b0;
    exp_dout0 = '0;
  endtask

  task automatic tick();
    bit emp, pa, ua, pa0, ua0;
    int n;
    ent_t e;
    emp = model_empty();
    n   = q.size();
    pa  = a_pop && !a_flush && !emp;
    ua  = a_push && !a_flush && (n < DEPTH || pa);
    pa0 = b_pop && q0.size() > 0;
    ua0 = b_push && (q0.size() < DEPTH || pa0);
    @(posedge clk);
    ecnt++;
    exp_ovr = a_push && !a_flush && n == DEPTH && !pa;
    exp_udr = a_pop && !a_flush && emp;
    if (a_flush) begin
      q.delete();
      wr_idx = 0;
    end else begin
      if (pa) void'(q.pop_front());
      if (ua) begin
        e.d  = a_din;
        e.pe = ecnt;
        q.push_back(e);
        shadow[wr_idx] = a_din;
        wr_idx = (wr_idx + 1) % DEPTH;
      end
    end
    if (pa0) exp_dout0 = q0.pop_front();
    if (ua0) q0.push_back(b_din);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    af_thr = 5'd0;
    #2;
    vectors++;
    if (a_af !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_af_thr0: got %0b want 1", a_af);
    end
    af_thr = 5'd12;
    #1;
    vectors++;
    if (a_depth !== 5'd0 || a_empty !== 1'b1 || a_full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: depth %0d empty %0b full %0b want 0 1 0",
               a_depth, a_empty, a_full);
    end
    vectors++;
    if (a_af !== 1'b0 || a_ae !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_flags: af %0b ae %0b want 0 1", a_af, a_ae);
    end
    vectors++;
    if (a_dout !== '0 || cpu_d !== '0 || cpu_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_data: dout %0h cpu %0h ack %0b want 0",
               a_dout, cpu_d, cpu_ack);
    end
    vectors++;
    if (a_ovr !== 1'b0 || a_udr !== 1'b0 || b_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_err: ovr %0b udr %0b b_empty %0b want 0 0 1",
               a_ovr, a_udr, b_empty);
    end
    model_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    a_push = 1'b1;
    a_din  = rnd();
    tick();
    a_push = 1'b0;
    vectors++;
    if (a_depth !== 5'(q.size()) || q.size() != 1) begin
      miscompares++;
      $display("FAIL release_push: depth %0d want 1", a_depth);
    end
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    vectors++;
    if (a_depth !== 5'd0 || a_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_after_release: depth %0d empty %0b want 0 1",
               a_depth, a_empty);
    end
  endtask

  task automatic test_fill_overrun();
    a_push = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      a_din = rnd();
      tick();
      vectors++;
      if (a_depth !== 5'(i + 1) || a_full !== (i == DEPTH - 1)) begin
        miscompares++;
        $display("FAIL fill_%0d: depth %0d full %0b want %0d %0b",
                 i, a_depth, a_full, i + 1, (i == DEPTH - 1));
      end
    end
    a_din = rnd();
    tick();
    a_push = 1'b0;
    vectors++;
    if (a_ovr !== 1'b1 || a_depth !== 5'd16) begin
      miscompares++;
      $display("FAIL overrun: ovr %0b depth %0d want 1 16", a_ovr, a_depth);
    end
    tick();
    vectors++;
    if (a_ovr !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_pulse: ovr %0b want 0", a_ovr);
    end
    vectors++;
    if (a_empty !== 1'b0 || a_dout !== q[0].d) begin
      miscompares++;
      $display("FAIL full_head: empty %0b dout %0h want 0 %0h",
               a_empty, a_dout, q[0].d);
    end
    vectors++;
    if (a_af !== 1'b1 || a_ae !== 1'b0) begin
      miscompares++;
      $display("FAIL full_flags: af %0b ae %0b want 1 0", a_af, a_ae);
    end
  endtask

  task automatic test_wrap_stream();
    a_push = 1'b1;
    a_pop  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a_din = rnd();
      tick();
      vectors++;
      if (a_depth !== 5'd16 || a_ovr !== 1'b0) begin
        miscompares++;
        $display("FAIL stream_%0d: depth %0d ovr %0b want 16 0",
                 i, a_depth, a_ovr);
      end
      vectors++;
      if (model_empty() || a_dout !== q[0].d) begin
        miscompares++;
        $display("FAIL stream_data_%0d: got %0h want %0h",
                 i, a_dout, q[0].d);
      end
    end
    a_push = 1'b0;
    a_pop  = 1'b0;
  endtask

  task automatic test_flush_partial();
    a_pop = 1'b1;
    repeat (11) tick();
    a_pop = 1'b0;
    vectors++;
    if (a_depth !== 5'd5 || q.size() != 5) begin
      miscompares++;
      $display("FAIL drain_to_5: depth %0d want 5", a_depth);
    end
    a_flush = 1'b1;
    a_push  = 1'b1;
    a_pop   = 1'b1;
    a_din   = rnd();
    tick();
    a_flush = 1'b0;
    a_push  = 1'b0;
    a_pop   = 1'b0;
    vectors++;
    if (a_depth !== 5'd0 || a_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL flush: depth %0d empty %0b want 0 1", a_depth, a_empty);
    end
    vectors++;
    if (a_ovr !== 1'b0 || a_udr !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_err: ovr %0b udr %0b want 0 0", a_ovr, a_udr);
    end
    tick();
    vectors++;
    if (a_empty !== 1'b1 || a_depth !== 5'd0) begin
      miscompares++;
      $display("FAIL flush_settle: empty %0b depth %0d want 1 0",
               a_empty, a_depth);
    end
  endtask

  task automatic test_fwft_latency();
    logic [WIDTH-1:0] pat;
    pat    = 256'hA5;
    a_din  = pat;
    a_push = 1'b1;
    tick();
    a_push = 1'b0;
    vectors++;
    if (a_depth !== 5'd1 || a_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL fwft_t1: depth %0d empty %0b want 1 1", a_depth, a_empty);
    end
    tick();
    vectors++;
    if (a_empty !== 1'b0 || a_dout !== pat) begin
      miscompares++;
      $display("FAIL fwft_t2: empty %0b dout %0h want 0 a5", a_empty, a_dout);
    end
    a_pop = 1'b1;
    tick();
    vectors++;
    if (a_empty !== 1'b1 || a_depth !== 5'd0 || a_udr !== 1'b0) begin
      miscompares++;
      $display("FAIL fwft_pop: empty %0b depth %0d udr %0b want 1 0 0",
               a_empty, a_depth, a_udr);
    end
    tick();
    a_pop = 1'b0;
    vectors++;
    if (a_udr !== exp_udr || a_udr !== 1'b1) begin
      miscompares++;
      $display("FAIL underrun: udr %0b want 1", a_udr);
    end
    tick();
    vectors++;
    if (a_udr !== 1'b0) begin
      miscompares++;
      $display("FAIL underrun_pulse: udr %0b want 0", a_udr);
    end
  endtask

  task automatic test_fwft0_order();
    b_push = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      b_din = WIDTH'(v);
      tick();
    end
    b_push = 1'b0;
    b_pop  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (b_dout !== exp_dout0 || b_dout !== WIDTH'(i + 1)) begin
        miscompares++;
        $display("FAIL fwft0_data_%0d: got %0h want %0h", i, b_dout, i + 1);
      end
      vectors++;
      if (b_empty !== (q0.size() == 0) || b_depth !== 5'(q0.size())) begin
        miscompares++;
        $display("FAIL fwft0_state_%0d: empty %0b depth %0d want %0b %0d",
                 i, b_empty, b_depth, (q0.size() == 0), q0.size());
      end
    end
    b_pop = 1'b0;
    tick();
    vectors++;
    if (b_dout !== WIDTH'(3) || b_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL fwft0_hold: dout %0h empty %0b want 3 1", b_dout, b_empty);
    end
  endtask

  task automatic test_cpu_read();
    a_push = 1'b1;
    repeat (DEPTH) begin
      a_din = rnd();
      tick();
    end
    a_push = 1'b0;
    tick();
    cpu_v = 1'b1;
    cpu_a = 4'd3;
    tick();
    cpu_v = 1'b0;
    vectors++;
    if (cpu_ack !== 1'b1 || cpu_d !== shadow[3]) begin
      miscompares++;
      $display("FAIL cpu_idle: ack %0b data %0h want 1 %0h",
               cpu_ack, cpu_d, shadow[3]);
    end
    vectors++;
    if (a_depth !== 5'd16 || a_full !== 1'b1) begin
      miscompares++;
      $display("FAIL cpu_no_side: depth %0d full %0b want 16 1",
               a_depth, a_full);
    end
    tick();
    vectors++;
    if (cpu_ack !== 1'b0 || cpu_d !== shadow[3]) begin
      miscompares++;
      $display("FAIL cpu_hold: ack %0b data %0h want 0 %0h",
               cpu_ack, cpu_d, shadow[3]);
    end
    cpu_v = 1'b1;
    cpu_a = 4'd7;
    a_pop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      cpu_a = 4'd9;
      if (i == 1) cpu_v = 1'b0;
      vectors++;
      if (cpu_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL cpu_defer_%0d: ack %0b want 0", i, cpu_ack);
      end
    end
    a_pop = 1'b0;
    tick();
    vectors++;
    if (cpu_ack !== 1'b1 || cpu_d !== shadow[7]) begin
      miscompares++;
      $display("FAIL cpu_deferred: ack %0b data %0h want 1 %0h",
               cpu_ack, cpu_d, shadow[7]);
    end
    tick();
    vectors++;
    if (cpu_ack !== 1'b0 || a_depth !== 5'(q.size()) || a_dout !== q[0].d) begin
      miscompares++;
      $display("FAIL cpu_after: ack %0b depth %0d want 0 %0d",
               cpu_ack, a_depth, q.size());
    end
  endtask

  task automatic test_random();
    int pp;
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    for (int k = 0; k < 400; k++) begin
      pp = ((k / 60) % 2 == 1) ? 75 : 35;
      if (k % 50 == 0) begin
        af_thr = 5'($urandom_range(0, 16));
        ae_thr = 5'($urandom_range(0, 16));
      end
      a_push  = ($urandom_range(0, 99) < pp);
      a_pop   = ($urandom_range(0, 99) < 50);
      a_flush = ($urandom_range(0, 99) < 2);
      a_din   = rnd();
      tick();
      vectors++;
      if (a_depth !== 5'(q.size()) || a_full !== (q.size() == DEPTH) ||
          a_empty !== model_empty()) begin
        miscompares++;
        $display("FAIL rnd_state_%0d: depth %0d full %0b empty %0b want %0d %0b %0b",
                 k, a_depth, a_full, a_empty, q.size(),
                 (q.size() == DEPTH), model_empty());
      end
      vectors++;
      if (a_af !== (q.size() >= int'(af_thr)) ||
          a_ae !== (q.size() <= int'(ae_thr))) begin
        miscompares++;
        $display("FAIL rnd_flags_%0d: af %0b ae %0b depth %0d thr %0d %0d",
                 k, a_af, a_ae, q.size(), af_thr, ae_thr);
      end
      vectors++;
      if (a_ovr !== exp_ovr || a_udr !== exp_udr) begin
        miscompares++;
        $display("FAIL rnd_err_%0d: ovr %0b udr %0b want %0b %0b",
                 k, a_ovr, a_udr, exp_ovr, exp_udr);
      end
      if (!model_empty()) begin
        vectors++;
        if (a_dout !== q[0].d) begin
          miscompares++;
          $display("FAIL rnd_data_%0d: got %0h want %0h", k, a_dout, q[0].d);
        end
      end
    end
    a_push  = 1'b0;
    a_pop   = 1'b0;
    a_flush = 1'b0;
    af_thr  = 5'd12;
    ae_thr  = 5'd3;
  endtask

  task automatic test_async_reset();
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    a_push  = 1'b1;
    repeat (9) begin
      a_din = rnd();
      tick();
    end
    a_push = 1'b0;
    vectors++;
    if (a_depth !== 5'd9) begin
      miscompares++;
      $display("FAIL pre_reset_depth: got %0d want 9", a_depth);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (a_depth !== 5'd0 || a_empty !== 1'b1 || a_full !== 1'b0 ||
        a_ae !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: depth %0d empty %0b full %0b ae %0b",
               a_depth, a_empty, a_full, a_ae);
    end
    vectors++;
    if (a_dout !== '0 || cpu_d !== '0 || cpu_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_data: dout %0h cpu %0h ack %0b want 0",
               a_dout, cpu_d, cpu_ack);
    end
    model_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    a_push = 1'b1;
    a_din  = rnd();
    tick();
    a_push = 1'b0;
    vectors++;
    if (a_depth !== 5'd1) begin
      miscompares++;
      $display("FAIL post_reset_push: depth %0d want 1", a_depth);
    end
    tick();
    vectors++;
    if (a_empty !== 1'b0 || a_dout !== q[0].d) begin
      miscompares++;
      $display("FAIL post_reset_data: empty %0b dout %0h want 0 %0h",
               a_empty, a_dout, q[0].d);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    a_flush = 1'b0;
    a_push  = 1'b0;
    a_pop   = 1'b0;
    a_din   = '0;
    af_thr  = 5'd12;
    ae_thr  = 5'd3;
    cpu_v   = 1'b0;
    cpu_a   = 4'd0;
    b_flush = 1'b0;
    b_push  = 1'b0;
    b_pop   = 1'b0;
    b_din   = '0;
    b_cpu_v = 1'b0;
    b_cpu_a = 4'd0;
    test_reset();
    test_fill_overrun();
    test_wrap_stream();
    test_flush_partial();
    test_fwft_latency();
    test_fwft0_order();
    test_cpu_read();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/param_ram_fifo.md
PARAM_RAM_FIFO -- requirements
Module: param_ram_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entries; power of two, 4..1024; AW = log2(DEPTH).
REQ-002 SHALL have parameter WIDTH, default 256, data bits per entry, 1..1024.
REQ-003 SHALL have parameter FWFT, default 1; 1 = first-word-fall-through, 0 = registered pop-then-read.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clockCore  in  1  sole clock, rising edge.
REQ-006 resetCore  in  1  asynchronous active-low reset.
REQ-007 flush  in  1  synchronous clear of FIFO state.
REQ-008 push  in  1  write request; dataIn  in  WIDTH  write data.
REQ-009 pop  in  1  read request; dataOut  out  WIDTH  read data.
REQ-010 almostFullThreshold, almostEmptyThreshold  in  AW+1 each  level thresholds.
REQ-011 full, empty, almostFullFlag, almostEmptyFlag  out  1 each  status.
REQ-012 fifoDepth  out  AW+1  occupancy, 0..DEPTH; overrun, underrun  out  1 each  error pulses.
REQ-013 cpuReadValid  in  1, cpuReadAddress  in  AW  debug read request; cpuReadAck  out  1, cpuReadData  out  WIDTH  debug response.

Function
REQ-014 Storage SHALL be an internal DEPTH x WIDTH two-port RAM with one write port and one synchronous read port of 1-cycle latency.
REQ-015 Write/read pointers SHALL be AW bits and wrap DEPTH-1 -> 0; fifoDepth counts every stored word, including any word held on dataOut in FWFT mode.
REQ-016 full SHALL be (fifoDepth == DEPTH); almostFullFlag SHALL be (fifoDepth >= almostFullThreshold); almostEmptyFlag SHALL be (fifoDepth <= almostEmptyThreshold); all from registered count, with no extra latency.
REQ-017 A push SHALL be accepted when !full, or when full with a pop accepted the same cycle (count unchanged).
REQ-018 A push while full without an accepted pop SHALL be dropped; overrun SHALL pulse for 1 cycle; state unchanged.
REQ-019 A pop while empty SHALL be ignored; underrun SHALL pulse for 1 cycle; a push in the same cycle SHALL still be accepted.
REQ-020 FWFT=0: empty = (fifoDepth == 0); an accepted pop SHALL update dataOut on the following clock edge; dataOut SHALL hold between pops.
REQ-021 FWFT=1: the block SHALL prefetch the head word into an output register; empty = !outputValid; a word pushed into an empty FIFO SHALL appear on dataOut with empty=0 two cycles after the push cycle.
REQ-022 FWFT=1: a pop SHALL consume the word on dataOut; the next word, if stored, SHALL be on dataOut the following cycle with no bubble under continuous pop.
REQ-023 CPU read: a cpuReadValid pulse SHALL capture cpuReadAddress into a single pending slot; cpuReadValid while a request is pending SHALL be ignored.
REQ-024 The RAM read port SHALL grant FIFO reads (pop or prefetch) before the pending CPU read; the CPU read SHALL issue on the first cycle the port is free, which can be the request cycle itself.
REQ-025 cpuReadAck SHALL pulse 1 cycle, one cycle after the CPU read issues, with cpuReadData = RAM[address]; cpuReadData SHALL hold until the next ack.
REQ-026 CPU reads SHALL NOT alter pointers, count or flags; the address is the physical RAM index, not relative to the read pointer.
REQ-027 flush SHALL zero pointers, count and outputValid and cancel any pending CPU read; push/pop in the flush cycle SHALL be ignored with no overrun/underrun; RAM contents are not cleared.

Reset
REQ-028 On resetCore low, all state SHALL clear asynchronously: dataOut=0, cpuReadData=0, fifoDepth=0, full=0, empty=1, almostFullFlag=(almostFullThreshold==0), almostEmptyFlag=1, overrun=0, underrun=0, cpuReadAck=0, no pending CPU read.
REQ-029 Reset release SHALL take effect synchronously; a push in the first cycle after release SHALL be accepted.

Verification (DEPTH=16, WIDTH=256, FWFT=1 unless stated)
REQ-030 16 pushes, no pop -> full=1 and fifoDepth=16 after the 16th; a 17th push -> overrun 1-cycle pulse, fifoDepth stays 16.
REQ-031 Push 0xA5 into empty -> dataOut=0xA5, empty=0 two cycles later; pop -> empty=1, fifoDepth=0 next cycle; a further pop -> underrun pulse.
REQ-032 Full FIFO with push+pop every cycle for 40 cycles -> fifoDepth stays 16, no overrun, output order equals input order across pointer wrap.
REQ-033 FWFT=0, push 1,2,3, then pop 3 cycles -> dataOut = 1,2,3 on the edges following each pop; empty=1 after the third.
REQ-034 cpuReadValid with address 3 while idle -> cpuReadAck next cycle with RAM[3]; the same request during continuous pop -> ack deferred until pop stops, then 1 cycle later.
REQ-035 resetCore low mid-stream with 9 words stored -> outputs go to reset values immediately without a clock; flush with 5 words stored -> fifoDepth=0, empty=1 next cycle.
